// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/writeback,
// owns the shared memory port, counts retired instructions and traps on faults.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    logic [3:0]  state, state_nxt;
    logic [15:0] tmo_cnt;
    logic        mem_wait, tmo_hit, retire;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^instr[31:7];
    assign state_o = state;

    assign mem_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A ready on the final allowed cycle still completes; only a low ready traps.
    assign tmo_hit  = mem_wait && !mem_ready && (tmo_cnt == TMO_LAST);
    assign retire   = (state_nxt == S_FETCH) &&
                      ((state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_MEM_WR) ||
                       (state == S_BRANCH) || (state == S_JAL));

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
                      else if (tmo_hit) state_nxt = S_TRAP;
            S_DECODE: begin
                case (instr[6:0])
                    OP_R:               state_nxt = S_EXEC_R;
                    OP_I:               state_nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
                    OP_BRANCH:          state_nxt = S_BRANCH;
                    OP_JAL:             state_nxt = S_JAL;
                    default:            state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
            S_MEM_ADDR: state_nxt = (instr[6:0] == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_nxt = S_WB_MEM;
                      else if (tmo_hit) state_nxt = S_TRAP;
            S_MEM_WR: if (mem_ready) state_nxt = S_FETCH;
                      else if (tmo_hit) state_nxt = S_TRAP;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        case (state)
            S_FETCH:    begin mem_req = 1'b1; ir_we = mem_ready; pc_we = mem_ready; end
            S_EXEC_R:   alu_op = 2'b10;
            S_EXEC_I:   begin alu_src_b = 2'b01; alu_op = 2'b10; end
            S_MEM_ADDR: alu_src_b = 2'b01;
            S_MEM_RD:   mem_req = 1'b1;
            S_MEM_WR:   begin mem_req = 1'b1; mem_we = 1'b1; end
            S_WB_ALU:   reg_we = 1'b1;
            S_WB_MEM:   begin reg_we = 1'b1; wb_sel = 2'b01; end
            S_BRANCH:   begin
                alu_op = 2'b01;
                pc_we  = branch_taken;
                pc_src = branch_taken ? 2'b01 : 2'b00;
            end
            S_JAL:      begin reg_we = 1'b1; wb_sel = 2'b10; pc_we = 1'b1; pc_src = 2'b01; end
            default:    ;
        endcase
        // Reset kills any in-flight access in the same cycle.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt    <= '0;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            if (state_nxt != state)           tmo_cnt <= '0;
            else if (mem_wait && !mem_ready)  tmo_cnt <= tmo_cnt + 16'd1;
            if (retire) instret <= instret + CNT_W'(1);
            if (state != S_TRAP && state_nxt == S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= (state == S_DECODE) ? 2'b01 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each instruction is expanded into its expected
// per-cycle state path and the Moore outputs of that path are checked every cycle.
module tb_mc_control_fsm;
    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        reset, mem_ready, branch_taken;
    logic [31:0] instr;
    logic        mem_req, mem_we, ir_we, pc_we, alu_src_a, reg_we, trap;
    logic [1:0]  pc_src, alu_src_b, alu_op, wb_sel, trap_cause;
    logic [3:0]  state_o;
    logic [31:0] instret;

    mc_control_fsm #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        mem_req, mem_we, ir_we, pc_we;
        logic [1:0]  pc_src;
        logic        a;
        logic [1:0]  b, op;
        logic        reg_we;
        logic [1:0]  wb;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] instret;
    } ov_t;

    typedef struct {
        ov_t   v;
        string name;
    } exp_t;

    exp_t        expq[$];
    int          n_chk = 0, n_fail = 0;
    string       tname = "init";
    logic [31:0] m_instret = '0;
    logic        m_trap = 1'b0;
    logic [1:0]  m_cause = 2'b00;

    // Expected outputs for one cycle spent in state st, straight from the state table.
    function automatic ov_t model(input int st, input bit rdy, input bit tk, input bit rst);
        ov_t o = '0;
        o.st = 4'(st);
        o.trap = m_trap;
        o.cause = m_cause;
        o.instret = m_instret;
        case (st)
            0:  begin o.mem_req = 1; o.ir_we = rdy; o.pc_we = rdy; end
            2:  o.op = 2'b10;
            3:  begin o.b = 2'b01; o.op = 2'b10; end
            4:  o.b = 2'b01;
            5:  o.mem_req = 1;
            6:  begin o.mem_req = 1; o.mem_we = 1; end
            7:  o.reg_we = 1;
            8:  begin o.reg_we = 1; o.wb = 2'b01; end
            9:  begin o.op = 2'b01; o.pc_we = tk; o.pc_src = tk ? 2'b01 : 2'b00; end
            10: begin o.reg_we = 1; o.wb = 2'b10; o.pc_we = 1; o.pc_src = 2'b01; end
            default: ;
        endcase
        if (rst) begin o.mem_req = 0; o.ir_we = 0; o.pc_we = 0; o.reg_we = 0; end
        return o;
    endfunction

    function automatic string fmt(input ov_t o);
        return $sformatf("st=%0d req=%b we=%b ir=%b pcwe=%b pcsrc=%b a=%b b=%b op=%b rwe=%b wb=%b trap=%b cause=%b ret=%0d",
                         o.st, o.mem_req, o.mem_we, o.ir_we, o.pc_we, o.pc_src, o.a, o.b, o.op,
                         o.reg_we, o.wb, o.trap, o.cause, o.instret);
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            ov_t  got;
            e = expq.pop_front();
            got = {state_o, mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                   alu_op, reg_we, wb_sel, trap, trap_cause, instret};
            // mem_we carries no meaning without a request
            if (!e.v.mem_req) begin got.mem_we = 1'b0; e.v.mem_we = 1'b0; end
            n_chk++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %s required %s", e.name, fmt(got), fmt(e.v));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    // Drive one cycle; st < 0 means the state is not yet defined and is not checked.
    task automatic cyc(input int st, input bit rdy, input bit tk = 1'b0, input bit rst = 1'b0);
        exp_t e;
        reset = rst;
        mem_ready = rdy;
        branch_taken = tk;
        if (st >= 0) begin
            e.v = model(st, rdy, tk, rst);
            e.name = $sformatf("%s/st%0d", tname, st);
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cur_st);
        cyc(cur_st, 1'b1, 1'b0, 1'b1);
        m_instret = '0;
        m_trap = 1'b0;
        m_cause = 2'b00;
    endtask

    task automatic enter_trap(input logic [1:0] cause);
        m_trap = 1'b1;
        m_cause = cause;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) cyc(0, 1'b0);
        cyc(0, 1'b1);
    endtask

    // Expected state path of one instruction, chosen from its opcode class.
    task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input bit tk);
        instr = ins;
        fetch(fw);
        cyc(1, 1'b1);
        case (ins[6:0])
            7'b0110011: begin cyc(2, 1'b1); cyc(7, 1'b1); m_instret = m_instret + 1; end
            7'b0010011: begin cyc(3, 1'b1); cyc(7, 1'b1); m_instret = m_instret + 1; end
            7'b0000011: begin
                cyc(4, 1'b1);
                for (int i = 0; i < mw; i++) cyc(5, 1'b0);
                cyc(5, 1'b1);
                cyc(8, 1'b1);
                m_instret = m_instret + 1;
            end
            7'b0100011: begin
                cyc(4, 1'b1);
                for (int i = 0; i < mw; i++) cyc(6, 1'b0);
                cyc(6, 1'b1);
                m_instret = m_instret + 1;
            end
            7'b1100011: begin cyc(9, 1'b1, tk); m_instret = m_instret + 1; end
            7'b1101111: begin cyc(10, 1'b1); m_instret = m_instret + 1; end
            default: enter_trap(2'b01);
        endcase
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; instr = 32'h0;
        @(posedge clk); #1;
        cyc(-1, 1'b1, 1'b0, 1'b1);
        tname = "reset";
        do_reset(0);
        chk("reset_state", 32'(state_o), 32'd0);

        tname = "addi";  do_instr(32'h00500093, 0, 0, 1'b0);
        chk("addi_instret", instret, 32'd1);
        tname = "lw";    do_instr(32'h0000A103, 0, 2, 1'b0);
        chk("lw_instret", instret, 32'd2);
        tname = "beq_t"; do_instr(32'h00208463, 0, 0, 1'b1);
        tname = "beq_n"; do_instr(32'h00208463, 1, 0, 1'b0);
        chk("beq_instret", instret, 32'd4);
        tname = "add";   do_instr(32'h002081B3, 2, 0, 1'b0);
        tname = "jal";   do_instr(32'h008000EF, 0, 0, 1'b0);
        tname = "sw";    do_instr(32'h0020A023, 0, 1, 1'b0);
        chk("seq_instret", instret, 32'd7);

        tname = "sw_abort";
        do_reset(0);
        instr = 32'h0020A023;
        fetch(0);
        cyc(1, 1'b1);
        cyc(4, 1'b1);
        cyc(6, 1'b0);
        do_reset(6);
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_instret", instret, 32'd0);

        tname = "illegal";
        do_instr(32'h00000000, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(15, i[0], i[1]);
        chk("illegal_state", 32'(state_o), 32'd15);
        chk("illegal_cause", 32'(trap_cause), 32'd1);
        do_reset(15);
        chk("illegal_reset_trap", 32'(trap), 32'd0);

        tname = "fetch_tmo";
        for (int i = 0; i < MT; i++) cyc(0, 1'b0);
        enter_trap(2'b10);
        for (int i = 0; i < 3; i++) cyc(15, 1'b1);
        chk("tmo_cause", 32'(trap_cause), 32'd2);
        do_reset(15);

        tname = "fetch_late_ok";
        do_instr(32'h00500093, MT - 1, 0, 1'b0);
        chk("late_ok_instret", instret, 32'd1);

        tname = "rd_tmo";
        instr = 32'h0000A103;
        fetch(0);
        cyc(1, 1'b1);
        cyc(4, 1'b1);
        for (int i = 0; i < MT; i++) cyc(5, 1'b0);
        enter_trap(2'b10);
        cyc(15, 1'b1);
        cyc(15, 1'b1);
        chk("rd_tmo_instret", instret, 32'd1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main controller for the RV32I datapath: IR, PC/oldPC registers, register file, ALU, immediate generator, and a single shared instruction/data memory port.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and mux selects, and arbitrates the one memory port between fetch and load/store.
- Counts retired instructions; traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: consecutive mem_ready-low cycles in a memory-wait state before a bus-timeout trap. Legal range 1..65535.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  IR contents; opcode instr[6:0].
- mem_ready  in  1  memory handshake; sampled only while mem_req=1.
- branch_taken  in  1  ALU compare result; valid in the BRANCH state.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store, 0 = read; meaningful only with mem_req.
- ir_we  out  1  load IR and oldPC.
- pc_we  out  1  load PC.
- pc_src  out  2  PC source: 00 = PC+4, 01 = oldPC+imm.
- alu_src_a  out  1  ALU A: 0 = rs1, 1 = oldPC.
- alu_src_b  out  2  ALU B: 00 = rs2, 01 = imm, 10 = const 4.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- reg_we  out  1  register-file write enable.
- wb_sel  out  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = oldPC+4.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = bus timeout.
- state_o  out  4  current state encoding, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Moore outputs decoded from state; exceptions are noted per state. All unlisted outputs are 0 in each state.
- Reset (clk edge with reset=1) sets state=FETCH, trap=0, trap_cause=00, instret=0, timeout counter=0.
- While reset=1, all enables are forced to 0: mem_req, ir_we, pc_we, reg_we.
- Reset has priority in every state. It aborts an in-flight access; mem_req drops the same cycle reset is high.
- State encoding (state_o): FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, TRAP=15.
- FETCH: mem_req=1, mem_we=0. Stay while mem_ready=0. In the mem_ready=1 cycle: ir_we=1, pc_we=1, pc_src=00; next state DECODE. Minimum 1 cycle.
- DECODE: 1 cycle. Dispatch on instr[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 -> MEM_ADDR
  - 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other value, including instr=32'h0 -> TRAP with cause 01.
- EXEC_R: a=0, b=00, op=10 -> WB_ALU.
- EXEC_I: a=0, b=01, op=10 -> WB_ALU.
- WB_ALU: reg_we=1, wb_sel=00 -> FETCH; retire.
- MEM_ADDR: a=0, b=01, op=00. Next state MEM_RD if opcode is 0000011, else MEM_WR.
- MEM_RD: mem_req=1, mem_we=0; wait for mem_ready, then -> WB_MEM.
- WB_MEM: reg_we=1, wb_sel=01 -> FETCH; retire.
- MEM_WR: mem_req=1, mem_we=1; wait for mem_ready, then -> FETCH; retire.
- BRANCH: a=0, b=00, op=01. If branch_taken: pc_we=1, pc_src=01. Next FETCH; retire.
- JAL: reg_we=1, wb_sel=10, pc_we=1, pc_src=01 -> FETCH; retire.
- Retire: instret increments by 1 on the transition into FETCH from a completing state. Wraps modulo 2^CNT_W. Never increments in TRAP or on reset.
- Timeout:
  - The counter clears on entry to FETCH, MEM_RD and MEM_WR.
  - It increments each cycle in those states with mem_ready=0.
  - If it reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP with cause 10. The timeout wins over a mem_ready arriving the following cycle.
  - mem_ready=1 on the same edge the count would hit MEM_TIMEOUT counts as success.
- TRAP: absorbing. trap=1, all enables 0, trap_cause held. Exit only via reset.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready tied 1 -> states 0,1,3,7 in 4 cycles; ir_we in cycle 1; reg_we=1, wb_sel=00 in cycle 4; instret 0->1.
- LW (0x0000A103) with data mem_ready asserted on the 3rd MEM_RD cycle -> mem_req, mem_we=0 held 3 cycles; WB_MEM has wb_sel=01; total 7 cycles; instret +1.
- BEQ (0x00208463): branch_taken=1 -> pc_we=1, pc_src=01 in BRANCH. Repeat with branch_taken=0 -> pc_we=0. Both return to FETCH; instret +1 each.
- instr=0x00000000 -> TRAP after DECODE; trap=1, trap_cause=01, state_o=15 held 20 cycles; reset -> FETCH, trap=0, instret=0.
- MEM_TIMEOUT=4, fetch with mem_ready held 0 -> TRAP after 4 wait cycles, cause 10. Separate run: mem_ready=1 on the 4th wait cycle -> no trap, DECODE.
- SW (0x0020A023), reset asserted during the 2nd MEM_WR cycle -> mem_req=0 that cycle, state FETCH next, instret unchanged at 0.
